// File: rtl/multi_cycle_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, state
// encodings, instruction classes, ALUOp codes and PCSrc/RegDst encodings.
// The jump-and-link opcodes are only legal when MCU_JUMP_LINK_EN is defined.
package multi_cycle_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b011100;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_BGTZ = 6'b110010;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ST_IF     = 3'b000,
    ST_ID     = 3'b001,
    ST_EXE_LS = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB_LD  = 3'b100,
    ST_EXE_BR = 3'b101,
    ST_EXE_AL = 3'b110,
    ST_WB_AL  = 3'b111
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BEQ,
    CL_BNE,
    CL_BGTZ,
    CL_JUMP,
    CL_JR,
    CL_JAL,
    CL_HALT,
    CL_ILLEGAL
  } class_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

endpackage

// File: rtl/mcu_opcode_decode.sv
// Combinational opcode decoder: instruction class, ALU controls and legality.
// jr/jal decode as legal only when MCU_JUMP_LINK_EN is defined.
module mcu_opcode_decode
  import multi_cycle_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output class_e              class_o,
  output logic [2:0]          aluOp_o,
  output logic                extSel_o,
  output logic                aluSrcA_o,
  output logic                aluSrcB_o,
  output logic [1:0]          regDst_o,
  output logic                legal_o
);

  logic [OPCODE_W-1:0] lowOnly;

  // Classify the opcode; anything with non-zero upper bits is illegal
  always_comb begin
    class_o   = CL_ILLEGAL;
    aluOp_o   = ALU_ADD;
    extSel_o  = 1'b0;
    aluSrcA_o = 1'b0;
    aluSrcB_o = 1'b0;
    regDst_o  = REGDST_RA;
    lowOnly   = '0;
    lowOnly[5:0] = opcode_i[5:0];
    if (lowOnly == opcode_i) begin
      case (opcode_i[5:0])
        OP_ADD:  begin class_o = CL_ALU; aluOp_o = ALU_ADD; regDst_o = REGDST_RD; end
        OP_SUB:  begin class_o = CL_ALU; aluOp_o = ALU_SUB; regDst_o = REGDST_RD; end
        OP_AND:  begin class_o = CL_ALU; aluOp_o = ALU_AND; regDst_o = REGDST_RD; end
        OP_OR:   begin class_o = CL_ALU; aluOp_o = ALU_OR;  regDst_o = REGDST_RD; end
        OP_SLT:  begin class_o = CL_ALU; aluOp_o = ALU_SLT; regDst_o = REGDST_RD; end
        OP_SLL:  begin
          class_o = CL_ALU; aluOp_o = ALU_SLL; regDst_o = REGDST_RD; aluSrcA_o = 1'b1;
        end
        OP_ADDI: begin
          class_o = CL_ALU; aluOp_o = ALU_ADD; regDst_o = REGDST_RT;
          aluSrcB_o = 1'b1; extSel_o = 1'b1;
        end
        OP_ORI:  begin
          class_o = CL_ALU; aluOp_o = ALU_OR; regDst_o = REGDST_RT; aluSrcB_o = 1'b1;
        end
        OP_SW:   begin class_o = CL_STORE; aluSrcB_o = 1'b1; extSel_o = 1'b1; end
        OP_LW:   begin class_o = CL_LOAD;  aluSrcB_o = 1'b1; extSel_o = 1'b1; end
        OP_BEQ:  begin class_o = CL_BEQ;  aluOp_o = ALU_CMP; extSel_o = 1'b1; end
        OP_BNE:  begin class_o = CL_BNE;  aluOp_o = ALU_CMP; extSel_o = 1'b1; end
        OP_BGTZ: begin class_o = CL_BGTZ; aluOp_o = ALU_SUB; extSel_o = 1'b1; end
        OP_J:    class_o = CL_JUMP;
        OP_HALT: class_o = CL_HALT;
`ifdef MCU_JUMP_LINK_EN
        OP_JR:   class_o = CL_JR;
        OP_JAL:  class_o = CL_JAL;
`endif
        default: class_o = CL_ILLEGAL;
      endcase
    end
    legal_o = (class_o != CL_ILLEGAL);
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle controller: walks each instruction through IF/ID/EXE/MEM/WB
// and drives the datapath strobes. HALT reuses the IF encoding plus a flag.
// Optional MCU_JUMP_LINK_EN adds jr/jal, both finishing in ID.
module multi_cycle_control_unit
  import multi_cycle_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                zero,
  input  logic                sign,
  output logic                PCWre,
  output logic                IRWre,
  output logic                RegWre,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic                DBDataSrc,
  output logic                WrRegDSrc,
  output logic                nRD,
  output logic                nWR,
  output logic [1:0]          RegDst,
  output logic                ExtSel,
  output logic [1:0]          PCSrc,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [2:0]          State,
  output logic                Halted,
  output logic                Illegal
);

  state_e     state_q, state_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;

  class_e     decClass;
  logic [2:0] decAluOp;
  logic       decExtSel, decAluSrcA, decAluSrcB, decLegal;
  logic [1:0] decRegDst;
  logic [2:0] aluOpSel;
  logic       branchTaken;

  mcu_opcode_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode_i  (Opcode),
    .class_o   (decClass),
    .aluOp_o   (decAluOp),
    .extSel_o  (decExtSel),
    .aluSrcA_o (decAluSrcA),
    .aluSrcB_o (decAluSrcB),
    .regDst_o  (decRegDst),
    .legal_o   (decLegal)
  );

  // Next state, halt flag and sticky illegal flag
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    if (!halted_q) begin
      case (state_q)
        ST_IF: state_d = ST_ID;
        ST_ID: begin
          state_d = ST_IF;
          if (!decLegal) begin
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end else begin
            case (decClass)
              CL_ALU:                 state_d = ST_EXE_AL;
              CL_LOAD, CL_STORE:      state_d = ST_EXE_LS;
              CL_BEQ, CL_BNE, CL_BGTZ: state_d = ST_EXE_BR;
              CL_HALT:                halted_d = 1'b1;
              default:                state_d = ST_IF;
            endcase
          end
        end
        ST_EXE_AL: state_d = ST_WB_AL;
        ST_EXE_LS: state_d = ST_MEM;
        ST_MEM:    state_d = (decClass == CL_LOAD) ? ST_WB_LD : ST_IF;
        default:   state_d = ST_IF;
      endcase
    end
  end

  // State register; reset returns to IF and clears the halt/illegal flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IF;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Per-state datapath strobes; reset and HALT leave everything idle
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b1;
    nRD       = 1'b1;
    nWR       = 1'b1;
    RegDst    = REGDST_RA;
    ExtSel    = 1'b0;
    PCSrc     = PCSRC_PC4;
    aluOpSel  = ALU_ADD;
    branchTaken = 1'b0;
    if (!RST && !halted_q) begin
      case (state_q)
        ST_IF: IRWre = 1'b1;
        ST_ID: begin
          case (decClass)
            CL_ALU: begin
              ALUSrcA = decAluSrcA; ALUSrcB = decAluSrcB; ExtSel = decExtSel;
              RegDst = decRegDst; aluOpSel = decAluOp;
            end
            CL_JUMP: begin PCWre = 1'b1; PCSrc = PCSRC_JUMP; end
`ifdef MCU_JUMP_LINK_EN
            CL_JR:   begin PCWre = 1'b1; PCSrc = PCSRC_RS; end
            CL_JAL:  begin
              PCWre = 1'b1; PCSrc = PCSRC_JUMP; RegWre = 1'b1;
              RegDst = REGDST_RA; WrRegDSrc = 1'b0;
            end
`endif
            default: ;
          endcase
        end
        ST_EXE_AL, ST_WB_AL: begin
          ALUSrcA = decAluSrcA; ALUSrcB = decAluSrcB; ExtSel = decExtSel;
          RegDst = decRegDst; aluOpSel = decAluOp;
          if (state_q == ST_WB_AL) begin
            RegWre = 1'b1; PCWre = 1'b1;
          end
        end
        ST_EXE_LS, ST_MEM: begin
          ALUSrcB = 1'b1; ExtSel = 1'b1; aluOpSel = ALU_ADD;
          if (state_q == ST_MEM) begin
            if (decClass == CL_LOAD) begin
              nRD = 1'b0;
            end else begin
              nWR = 1'b0; PCWre = 1'b1;
            end
          end
        end
        ST_WB_LD: begin
          nRD = 1'b0; DBDataSrc = 1'b1; RegDst = REGDST_RT; RegWre = 1'b1; PCWre = 1'b1;
        end
        ST_EXE_BR: begin
          ExtSel = 1'b1; aluOpSel = decAluOp; PCWre = 1'b1;
          case (decClass)
            CL_BEQ:  branchTaken = zero;
            CL_BNE:  branchTaken = !zero;
            CL_BGTZ: branchTaken = !(zero | sign);
            default: branchTaken = 1'b0;
          endcase
          PCSrc = branchTaken ? PCSRC_BRANCH : PCSRC_PC4;
        end
        default: ;
      endcase
    end
  end

  // Zero-pad the 3-bit ALU code to the configured ALUOp width
  always_comb begin
    ALUOp = '0;
    ALUOp[2:0] = aluOpSel;
  end

  assign State   = state_q;
  assign Halted  = halted_q & ~RST;
  assign Illegal = illegal_q & ~RST;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit: each cycle's expected strobe
// vector is queued when the inputs are driven and checked on the falling edge.
// Jump-and-link expectations follow MCU_JUMP_LINK_EN.
module tb_multi_cycle_control_unit;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       irw;
    logic       regw;
    logic       srca;
    logic       srcb;
    logic       dbsrc;
    logic       wrsrc;
    logic       nrd;
    logic       nwr;
    logic [1:0] regdst;
    logic       ext;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       halted;
    logic       illegal;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic [5:0] Opcode;
  logic       zero, sign;
  logic       PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, nRD, nWR;
  logic [1:0] RegDst, PCSrc;
  logic       ExtSel;
  logic [2:0] ALUOp, State;
  logic       Halted, Illegal;

  exp_t  expQ[$];
  string tagQ[$];
  int    checks = 0;
  int    errors = 0;

  multi_cycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
    .nRD(nRD), .nWR(nWR), .RegDst(RegDst), .ExtSel(ExtSel), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .State(State), .Halted(Halted), .Illegal(Illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t idle(input logic [2:0] st);
    exp_t e;
    e       = '0;
    e.st    = st;
    e.wrsrc = 1'b1;
    e.nrd   = 1'b1;
    e.nwr   = 1'b1;
    return e;
  endfunction

  task automatic checkOutput();
    exp_t  e, obs;
    string tag;
    e   = expQ.pop_front();
    tag = tagQ.pop_front();
    obs = '{State, PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc,
            nRD, nWR, RegDst, ExtSel, PCSrc, ALUOp, Halted, Illegal};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic [5:0] op,
                               input logic z, input logic s, input exp_t e);
    RST = rst; Opcode = op; zero = z; sign = s;
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(negedge CLK);
    checkOutput();
    @(posedge CLK);
    #1;
  endtask

  task automatic aluInstr(input string tag, input logic [5:0] op, input logic srca,
                          input logic srcb, input logic ext, input logic [1:0] rd,
                          input logic [2:0] aop);
    exp_t e;
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus({tag, "_if"}, 1'b0, op, 1'b0, 1'b0, e);
    e = idle(3'b001); e.srca = srca; e.srcb = srcb; e.ext = ext; e.regdst = rd; e.aluop = aop;
    applyStimulus({tag, "_id"}, 1'b0, op, 1'b0, 1'b0, e);
    e.st = 3'b110;
    applyStimulus({tag, "_exe"}, 1'b0, op, 1'b0, 1'b0, e);
    e.st = 3'b111; e.regw = 1'b1; e.pcw = 1'b1;
    applyStimulus({tag, "_wb"}, 1'b0, op, 1'b0, 1'b0, e);
  endtask

  task automatic branchInstr(input string tag, input logic [5:0] op, input logic z,
                             input logic s, input logic [2:0] aop, input logic [1:0] pcs);
    exp_t e;
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus({tag, "_if"}, 1'b0, op, z, s, e);
    applyStimulus({tag, "_id"}, 1'b0, op, z, s, idle(3'b001));
    e = idle(3'b101); e.ext = 1'b1; e.aluop = aop; e.pcw = 1'b1; e.pcsrc = pcs;
    applyStimulus({tag, "_exe"}, 1'b0, op, z, s, e);
  endtask

  initial begin
    exp_t e;
    RST = 1'b1; Opcode = 6'b000000; zero = 1'b0; sign = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    applyStimulus("reset", 1'b1, 6'b000000, 1'b0, 1'b0, idle(3'b000));

    aluInstr("add",  6'b000000, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000);
    aluInstr("sll",  6'b011000, 1'b1, 1'b0, 1'b0, 2'b10, 3'b010);
    aluInstr("addi", 6'b000001, 1'b0, 1'b1, 1'b1, 2'b01, 3'b000);
    aluInstr("ori",  6'b010000, 1'b0, 1'b1, 1'b0, 2'b01, 3'b011);
    aluInstr("and",  6'b010001, 1'b0, 1'b0, 1'b0, 2'b10, 3'b100);
    aluInstr("slt",  6'b011100, 1'b0, 1'b0, 1'b0, 2'b10, 3'b110);

    // lw: IF -> ID -> EXE_LS -> MEM -> WB_LD
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus("lw_if", 1'b0, 6'b100111, 1'b0, 1'b0, e);
    applyStimulus("lw_id", 1'b0, 6'b100111, 1'b0, 1'b0, idle(3'b001));
    e = idle(3'b010); e.srcb = 1'b1; e.ext = 1'b1;
    applyStimulus("lw_exe", 1'b0, 6'b100111, 1'b0, 1'b0, e);
    e.st = 3'b011; e.nrd = 1'b0;
    applyStimulus("lw_mem", 1'b0, 6'b100111, 1'b0, 1'b0, e);
    e = idle(3'b100); e.nrd = 1'b0; e.dbsrc = 1'b1; e.regdst = 2'b01; e.regw = 1'b1; e.pcw = 1'b1;
    applyStimulus("lw_wb", 1'b0, 6'b100111, 1'b0, 1'b0, e);

    // sw completes from MEM
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus("sw_if", 1'b0, 6'b100110, 1'b0, 1'b0, e);
    applyStimulus("sw_id", 1'b0, 6'b100110, 1'b0, 1'b0, idle(3'b001));
    e = idle(3'b010); e.srcb = 1'b1; e.ext = 1'b1;
    applyStimulus("sw_exe", 1'b0, 6'b100110, 1'b0, 1'b0, e);
    e.st = 3'b011; e.nwr = 1'b0; e.pcw = 1'b1;
    applyStimulus("sw_mem", 1'b0, 6'b100110, 1'b0, 1'b0, e);

    branchInstr("beq_z1",  6'b110000, 1'b1, 1'b0, 3'b111, 2'b01);
    branchInstr("beq_z0",  6'b110000, 1'b0, 1'b0, 3'b111, 2'b00);
    branchInstr("bne_z1",  6'b110001, 1'b1, 1'b0, 3'b111, 2'b00);
    branchInstr("bgtz_p",  6'b110010, 1'b0, 1'b0, 3'b001, 2'b01);
    branchInstr("bgtz_n",  6'b110010, 1'b0, 1'b1, 3'b001, 2'b00);

    // j finishes in ID
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus("j_if", 1'b0, 6'b111000, 1'b0, 1'b0, e);
    e = idle(3'b001); e.pcw = 1'b1; e.pcsrc = 2'b11;
    applyStimulus("j_id", 1'b0, 6'b111000, 1'b0, 1'b0, e);

    // reset during sw MEM aborts the store
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus("swrst_if", 1'b0, 6'b100110, 1'b0, 1'b0, e);
    applyStimulus("swrst_id", 1'b0, 6'b100110, 1'b0, 1'b0, idle(3'b001));
    e = idle(3'b010); e.srcb = 1'b1; e.ext = 1'b1;
    applyStimulus("swrst_exe", 1'b0, 6'b100110, 1'b0, 1'b0, e);
    applyStimulus("swrst_mem", 1'b1, 6'b100110, 1'b0, 1'b0, idle(3'b011));
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus("swrst_after", 1'b0, 6'b100110, 1'b0, 1'b0, e);

    // undefined opcode -> Illegal and HALT, held until reset
    applyStimulus("ill_id", 1'b0, 6'b101010, 1'b0, 1'b0, idle(3'b001));
    for (int i = 0; i < 10; i++) begin
      e = idle(3'b000); e.halted = 1'b1; e.illegal = 1'b1;
      applyStimulus($sformatf("ill_hold%0d", i), 1'b0, 6'b000000, 1'b1, 1'b1, e);
    end
    applyStimulus("ill_rst", 1'b1, 6'b000000, 1'b0, 1'b0, idle(3'b000));
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus("ill_after", 1'b0, 6'b111111, 1'b0, 1'b0, e);

    // halt opcode: Halted without Illegal
    applyStimulus("halt_id", 1'b0, 6'b111111, 1'b0, 1'b0, idle(3'b001));
    for (int i = 0; i < 3; i++) begin
      e = idle(3'b000); e.halted = 1'b1;
      applyStimulus($sformatf("halt_hold%0d", i), 1'b0, 6'b000000, 1'b0, 1'b0, e);
    end
    applyStimulus("halt_rst", 1'b1, 6'b000000, 1'b0, 1'b0, idle(3'b000));

    // jal: link in ID when enabled, otherwise illegal
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus("jal_if", 1'b0, 6'b111010, 1'b0, 1'b0, e);
`ifdef MCU_JUMP_LINK_EN
    e = idle(3'b001); e.pcw = 1'b1; e.pcsrc = 2'b11; e.regw = 1'b1; e.regdst = 2'b00; e.wrsrc = 1'b0;
    applyStimulus("jal_id", 1'b0, 6'b111010, 1'b0, 1'b0, e);
    e = idle(3'b000); e.irw = 1'b1;
    applyStimulus("jal_next", 1'b0, 6'b111010, 1'b0, 1'b0, e);
`else
    applyStimulus("jal_id", 1'b0, 6'b111010, 1'b0, 1'b0, idle(3'b001));
    e = idle(3'b000); e.halted = 1'b1; e.illegal = 1'b1;
    applyStimulus("jal_ill", 1'b0, 6'b111010, 1'b0, 1'b0, e);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
